// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes a - b one bit per
//   clock, LSB first, and uses a start/busy/done handshake. The per-bit
//   full-subtractor cell is built at switch level from pmos/nmos devices on
//   the supply nets. Sequencing, the shift registers and the borrow flop are
//   behavioural RTL around that cell.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request a subtraction (sampled only in IDLE)
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out are published
//   diff       : (a - b) mod 2^WIDTH, held until the next completion
//   borrow_out : 1 iff a < b (unsigned), held until the next completion

`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // ---------------------------------------------------------------------
  // Switch-level full-subtractor cell.
  // Every stage is either a static CMOS inverter or a complementary
  // pass-transistor 2:1 mux, so each net has exactly one conducting path.
  //   p    = x ^ y          (mux on x: x ? ~y : y)
  //   d    = p ^ bin        (mux on bin: bin ? ~p : p)
  //   bout = p ? ~x : bin   (when x != y a borrow occurs exactly when x=0)
  // ---------------------------------------------------------------------
  supply1 vdd;
  supply0 gnd;

  wire cell_x;
  wire cell_y;
  wire cell_bin;
  wire x_n;
  wire y_n;
  wire p;
  wire p_n;
  wire cell_d;
  wire cell_bout;

  assign cell_x   = sa[0];
  assign cell_y   = sb[0];
  assign cell_bin = br;

  pmos u_xn_up   (x_n, vdd, cell_x);
  nmos u_xn_dn   (x_n, gnd, cell_x);
  pmos u_yn_up   (y_n, vdd, cell_y);
  nmos u_yn_dn   (y_n, gnd, cell_y);

  nmos u_p_hi    (p, y_n, cell_x);
  pmos u_p_lo    (p, cell_y, cell_x);

  pmos u_pn_up   (p_n, vdd, p);
  nmos u_pn_dn   (p_n, gnd, p);

  nmos u_d_hi    (cell_d, p_n, cell_bin);
  pmos u_d_lo    (cell_d, p, cell_bin);

  nmos u_bout_hi (cell_bout, x_n, p);
  pmos u_bout_lo (cell_bout, cell_bin, p);

  // The new difference bit enters at the MSB, so after WIDTH shifts bit 0
  // of the result sits at the LSB.
  assign sd_next  = {cell_d, sd[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // busy and done decode directly from the registered state, so they are
  // glitch-free and can never be high together.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. start only matters in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Operands load on the accepting edge. The published result
  // registers update only on the edge that processes the last bit, so a
  // partial result is never visible on diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          br  <= cell_bout;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            diff       <= sd_next;
            borrow_out <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH=8). Each accepted request
//   pushes its expected result and accepting-edge number. A negedge monitor
//   checks busy/done timing against the queue head, checks the result on
//   done, and checks that diff/borrow_out hold their last published value
//   at all other times.

`timescale 1ns/1ps

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    int               accept;
  } expEntry_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  expEntry_t        expQ[$];
  int               cycleCount = 0;
  int               checks     = 0;
  int               failures   = 0;
  logic [WIDTH-1:0] heldDiff   = '0;
  logic             heldBorrow = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable when read at a negedge.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic expEntry_t makeEntry(input logic [WIDTH-1:0] ta,
                                          input logic [WIDTH-1:0] tb,
                                          input int acceptEdge);
    expEntry_t e;
    e.diff   = ta - tb;
    e.borrow = (ta < tb);
    e.accept = acceptEdge;
    return e;
  endfunction

  // Wait (bounded) for IDLE, present operands with a one-cycle start
  // pulse and record the expected result for the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!busy && !done) found = 1;
    end
    if (!found) checkOutput("idleWait", {30'd0, busy, done}, 32'd0);
    a     = ta;
    b     = tb;
    start = 1'b1;
    expQ.push_back(makeEntry(ta, tb, cycleCount + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = WIDTH'($urandom_range(0, 255));
    b     = WIDTH'($urandom_range(0, 255));
  endtask

  // Bounded wait until every queued result has been seen.
  task automatic waitDrain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain", expQ.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: timing of busy/done against the queue head, result on done,
  // and result stability everywhere else.
  always @(negedge clk) begin
    logic      expBusy;
    logic      expDone;
    expEntry_t entry;
    if (rst_n) begin
      expBusy = 1'b0;
      expDone = 1'b0;
      if (expQ.size() > 0) begin
        expBusy = (cycleCount >= expQ[0].accept) &&
                  (cycleCount < expQ[0].accept + WIDTH);
        expDone = (cycleCount == expQ[0].accept + WIDTH);
      end
      checkOutput("busy", busy, expBusy);
      checkOutput("done", done, expDone);
      if ((done || expDone) && expQ.size() > 0) begin
        entry = expQ.pop_front();
        checkOutput("diff", diff, entry.diff);
        checkOutput("borrow", borrow_out, entry.borrow);
        heldDiff   = entry.diff;
        heldBorrow = entry.borrow;
      end else if (!done) begin
        checkOutput("diffHeld", diff, heldDiff);
        checkOutput("borrowHeld", borrow_out, heldBorrow);
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetDiff", diff, 0);
    checkOutput("resetBorrow", borrow_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed operand pairs, including the extremes.
    applyStimulus(8'd100, 8'd37);
    waitDrain();
    applyStimulus(8'd5, 8'd10);
    waitDrain();
    applyStimulus(8'd0, 8'd255);
    waitDrain();
    applyStimulus(8'd0, 8'd0);
    waitDrain();
    applyStimulus(8'd255, 8'd255);
    waitDrain();

    // A start pulse during the 3rd SHIFT cycle must be ignored.
    applyStimulus(8'd200, 8'd1);
    repeat (3) @(negedge clk);
    a     = 8'd3;
    b     = 8'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDrain();
    repeat (10) @(negedge clk);

    // Result of 100-37 must hold through 9-2 until its done cycle.
    applyStimulus(8'd100, 8'd37);
    waitDrain();
    applyStimulus(8'd9, 8'd2);
    waitDrain();

    // Asynchronous reset mid-SHIFT discards the operation.
    applyStimulus(8'd100, 8'd37);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    expQ.delete();
    heldDiff   = '0;
    heldBorrow = 1'b0;
    #1;
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDone", done, 0);
    checkOutput("midResetDiff", diff, 0);
    checkOutput("midResetBorrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    applyStimulus(8'd20, 8'd5);
    waitDrain();

    // start held high: one operation every WIDTH+2 cycles.
    begin
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
        @(negedge clk);
        if (!busy && !done) found = 1;
      end
      if (!found) checkOutput("idleWaitCont", {30'd0, busy, done}, 32'd0);
    end
    a     = 8'd10;
    b     = 8'd3;
    start = 1'b1;
    base  = cycleCount + 1;
    for (int k = 0; k < 3; k++)
      expQ.push_back(makeEntry(8'd10, 8'd3, base + k * (WIDTH + 2)));
    repeat (2 * (WIDTH + 2) + 1) @(negedge clk);
    start = 1'b0;
    waitDrain();

    // A few random operand pairs.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
      waitDrain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
